datapath_ctrl: RTL
==================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 SHALL have port Clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port Start  input  1  begin execution at StartAddr; honoured only in IDLE or HALTED.
REQ-004 SHALL have port StartAddr  input  16  first instruction address.
REQ-005 SHALL have port InstrReq  output  1  instruction-fetch request.
REQ-006 SHALL have port InstrAddr  output  16  fetch address (= PC).
REQ-007 SHALL have port InstrAck  input  1  fetch completes; InstrData valid same cycle.
REQ-008 SHALL have port InstrData  input  16  fetched instruction word.
REQ-009 SHALL have port Opcode  output  16  instruction to datapath ([15:12],[7:4] op; [11:8] dest/A; [3:0] B).
REQ-010 SHALL have port Cin  output  1  carry-in to datapath.
REQ-011 SHALL have port RegWrEn  output  1  register-file write qualifier for Opcode[11:8].
REQ-012 SHALL have port Flags  input  5  datapath flag result.
REQ-013 SHALL have port FlagReg  output  5  latched flags; bit 0 = carry.
REQ-014 SHALL have port Busy  output  1  high in FETCH or EXEC.
REQ-015 SHALL have port Halted  output  1  high in HALTED.

Function
REQ-016 SHALL implement states IDLE, FETCH, EXEC, HALTED.
REQ-017 IDLE/HALTED + Start: PC <= StartAddr, -> FETCH next cycle; Start ignored in FETCH/EXEC.
REQ-018 FETCH: InstrReq=1, InstrAddr=PC, both held stable until InstrAck; InstrAck while InstrReq=0 ignored.
REQ-019 FETCH + InstrAck: IR <= InstrData, PC <= PC+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-020 Decode on ack: InstrData[15:12]!=4'hF -> EXEC; else control class per REQ-021..023, no datapath issue.
REQ-021 Control 16'hF0xx (HALT): -> HALTED; PC points past HALT.
REQ-022 Control 16'hF1xx (SKIP): if FlagReg[InstrData[2:0]]=1 (index 0-4; 5-7 never true) PC <= PC+2 modulo 2^16, else PC+1; -> FETCH.
REQ-023 Other control words (F2xx-FFxx): NOP, PC+1, -> FETCH.
REQ-024 EXEC lasts exactly one cycle: RegWrEn=1, Opcode=IR; FlagReg <= Flags at the edge ending EXEC; -> FETCH.
REQ-025 Opcode SHALL equal IR in all states; RegWrEn SHALL be 0 outside EXEC.
REQ-026 Minimum ALU-instruction throughput: 2 cycles (FETCH with same-cycle ack, EXEC).
REQ-027 Busy and Halted are decoded from state, combinational, mutually exclusive.
REQ-028 FlagReg SHALL change only at end of EXEC or on reset.

Reset
REQ-029 Reset high at a rising edge: state IDLE, PC=16'h0000, IR=16'h0000, FlagReg=5'b00000.
REQ-030 Outputs after reset: InstrReq=0, InstrAddr=0, Opcode=0, RegWrEn=0, Cin=0, Busy=0, Halted=0.
REQ-031 Reset overrides Start and InstrAck in the same cycle; reset mid-FETCH/EXEC discards the instruction, no flag or register write.

Configuration
REQ-032 Macro DATAPATH_CTRL_CARRY_CHAIN_EN defined: Cin = FlagReg[0] in EXEC, 0 elsewhere.
REQ-033 Macro undefined: Cin tied to 0; all other behaviour identical.

Verification
REQ-034 Reset, Start with StartAddr=16'h0040, ack same cycle with 16'h0512 -> InstrAddr=0040, next cycle EXEC: Opcode=0512, RegWrEn=1 for exactly 1 cycle, FlagReg=Flags.
REQ-035 InstrAck delayed 3 cycles -> InstrReq, InstrAddr stable 3 cycles, RegWrEn stays 0 until EXEC.
REQ-036 FlagReg=5'b00100, fetch 16'hF102 at PC=0010 -> next InstrAddr=0012; with FlagReg=0 -> 0011.
REQ-037 StartAddr=16'hFFFF, ALU instr then HALT -> second fetch InstrAddr=0000, Halted=1, Busy=0, Start ignored until HALTED.
REQ-038 Reset asserted in EXEC -> RegWrEn=0 next cycle, FlagReg=0, state IDLE.
REQ-039 FlagReg[0]=1, ALU EXEC -> Cin=1 with DATAPATH_CTRL_CARRY_CHAIN_EN, Cin=0 without.

Source files
------------

// File: rtl/datapath_ctrl_if.sv
// Instruction-fetch bus between datapath_ctrl and instruction memory.
// Master issues the request; slave acks and returns the word the same cycle.
interface datapath_ctrl_if;
  logic        InstrReq;
  logic [15:0] InstrAddr;
  logic        InstrAck;
  logic [15:0] InstrData;

  modport master (
    output InstrReq,
    output InstrAddr,
    input  InstrAck,
    input  InstrData
  );

  modport slave (
    input  InstrReq,
    input  InstrAddr,
    output InstrAck,
    output InstrData
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Fetch/exec sequencer driving a register-file datapath.
// Optional macro DATAPATH_CTRL_CARRY_CHAIN_EN feeds FlagReg[0] to Cin in EXEC.
module datapath_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] StartAddr,
  datapath_ctrl_if.master ibus,
  output logic [15:0] Opcode,
  output logic        Cin,
  output logic        RegWrEn,
  input  logic [4:0]  Flags,
  output logic [4:0]  FlagReg,
  output logic        Busy,
  output logic        Halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALTED
  } state_t;

  state_t      state_q, state_n;
  logic [15:0] pc_q, pc_n;
  logic [15:0] ir_q, ir_n;
  logic [4:0]  flag_q, flag_n;
  logic [7:0]  fsel;
  logic        skip_hit;
  logic        is_ctrl;
  logic [3:0]  ctrl_cls;

  // Indices 5-7 land on the zero padding, so they never skip.
  assign fsel     = {3'b000, flag_q};
  assign skip_hit = fsel[ibus.InstrData[2:0]];
  assign is_ctrl  = (ibus.InstrData[15:12] == 4'hF);
  assign ctrl_cls = ibus.InstrData[11:8];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= 16'h0000;
      ir_q    <= 16'h0000;
      flag_q  <= 5'b00000;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ir_q    <= ir_n;
      flag_q  <= flag_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ir_n    = ir_q;
    flag_n  = flag_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          pc_n    = StartAddr;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (ibus.InstrAck) begin
          ir_n = ibus.InstrData;
          pc_n = pc_q + 16'd1;
          if (!is_ctrl) begin
            state_n = EXEC;
          end else if (ctrl_cls == 4'h0) begin
            state_n = HALTED;
          end else if (ctrl_cls == 4'h1) begin
            state_n = FETCH;
            if (skip_hit) pc_n = pc_q + 16'd2;
          end else begin
            state_n = FETCH;
          end
        end
      end
      EXEC: begin
        flag_n  = Flags;
        state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ibus.InstrReq  = (state_q == FETCH);
  assign ibus.InstrAddr = pc_q;
  assign Opcode         = ir_q;
  assign RegWrEn        = (state_q == EXEC);
  assign FlagReg        = flag_q;
  assign Busy           = (state_q == FETCH) ||
                          (state_q == EXEC);
  assign Halted         = (state_q == HALTED);

`ifdef DATAPATH_CTRL_CARRY_CHAIN_EN
  assign Cin = (state_q == EXEC) & flag_q[0];
`else
  assign Cin = 1'b0;
`endif

endmodule
